// File: rtl/morse_key_decoder_if.sv
// Key/tick inputs and symbol/letter result pulses of the Morse key decoder.
interface morse_key_decoder_if;
   localparam int unsigned LEN_W  = 3;
   localparam int unsigned BITS_W = 4;

   logic              tick;
   logic              key_in;
   logic              sym_valid;
   logic              sym_dash;
   logic              letter_valid;
   logic [LEN_W-1:0]  letter_len;
   logic [BITS_W-1:0] letter_bits;
   logic              err;

   modport master (
      output tick, key_in,
      input  sym_valid, sym_dash, letter_valid, letter_len, letter_bits, err
   );

   modport slave (
      input  tick, key_in,
      output sym_valid, sym_dash, letter_valid, letter_len, letter_bits, err
   );
endinterface

// File: rtl/morse_key_decoder.sv
// Times key presses and gaps in 100 ms ticks, classifies dots/dashes and
// packs them into letters released after the inter-letter gap.
module morse_key_decoder #(
   parameter int unsigned DASH_TICKS       = 3,
   parameter int unsigned LETTER_GAP_TICKS = 5,
   parameter int unsigned MAX_PRESS_TICKS  = 15,
   parameter int unsigned MAX_SYMBOLS      = 4
) (
   input  logic                clk,
   input  logic                rst,
   morse_key_decoder_if.slave  bus
);
   localparam int unsigned CNT_W = 4;
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned SYM_W = 3;
   localparam int unsigned BUF_W = 4;
   localparam int unsigned IDX_W = $clog2(BUF_W);

   typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_ERR} state_e;

   state_e             state_q, state_d;
   logic               key_meta_q, key_s_q, key_prev_q;
   logic [CNT_W-1:0]   press_cnt_q, press_cnt_d;
   logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
   logic [BUF_W-1:0]   sym_buf_q, sym_buf_d;
   logic               sym_valid_q, sym_valid_d;
   logic               sym_dash_q, sym_dash_d;
   logic               letter_valid_q, letter_valid_d;
   logic [SYM_W-1:0]   letter_len_q, letter_len_d;
   logic [BUF_W-1:0]   letter_bits_q, letter_bits_d;
   logic               err_q, err_d;

   logic               key_rise, key_fall, is_dash;
   logic [SUM_W-1:0]   press_sum, gap_sum;

   // Same-cycle tick is folded into both counts before any threshold compare.
   assign key_rise  = key_s_q & ~key_prev_q;
   assign key_fall  = ~key_s_q & key_prev_q;
   assign press_sum = SUM_W'(press_cnt_q) + SUM_W'(bus.tick);
   assign gap_sum   = SUM_W'(gap_cnt_q) + SUM_W'(bus.tick);
   assign is_dash   = (press_sum >= SUM_W'(DASH_TICKS));

   // Next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      press_cnt_d    = press_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      sym_cnt_d      = sym_cnt_q;
      sym_buf_d      = sym_buf_q;
      sym_valid_d    = 1'b0;
      sym_dash_d     = sym_dash_q;
      letter_valid_d = 1'b0;
      letter_len_d   = letter_len_q;
      letter_bits_d  = letter_bits_q;
      err_d          = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (key_rise) begin
               state_d     = S_PRESS;
               press_cnt_d = '0;
            end
         end
         S_PRESS: begin
            if (press_sum >= SUM_W'(MAX_PRESS_TICKS)) begin
               state_d   = S_ERR;
               err_d     = 1'b1;
               sym_cnt_d = '0;
               sym_buf_d = '0;
            end else if (key_fall) begin
               if (sym_cnt_q == SYM_W'(MAX_SYMBOLS)) begin
                  state_d   = S_ERR;
                  err_d     = 1'b1;
                  sym_cnt_d = '0;
                  sym_buf_d = '0;
               end else begin
                  state_d                        = S_GAP;
                  gap_cnt_d                      = '0;
                  sym_valid_d                    = 1'b1;
                  sym_dash_d                     = is_dash;
                  sym_buf_d[sym_cnt_q[IDX_W-1:0]] = is_dash;
                  sym_cnt_d                      = sym_cnt_q + SYM_W'(1);
               end
            end else begin
               press_cnt_d = press_sum[CNT_W-1:0];
            end
         end
         S_GAP: begin
            // A new press wins over the tick that would otherwise close the letter.
            if (key_rise) begin
               state_d     = S_PRESS;
               press_cnt_d = '0;
            end else if (gap_sum >= SUM_W'(LETTER_GAP_TICKS)) begin
               state_d        = S_IDLE;
               letter_valid_d = 1'b1;
               letter_len_d   = sym_cnt_q;
               letter_bits_d  = sym_buf_q;
               sym_cnt_d      = '0;
               sym_buf_d      = '0;
            end else begin
               gap_cnt_d = gap_sum[CNT_W-1:0];
            end
         end
         S_ERR: begin
            if (!key_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, synchronizer and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         key_meta_q     <= 1'b0;
         key_s_q        <= 1'b0;
         key_prev_q     <= 1'b0;
         press_cnt_q    <= '0;
         gap_cnt_q      <= '0;
         sym_cnt_q      <= '0;
         sym_buf_q      <= '0;
         sym_valid_q    <= 1'b0;
         sym_dash_q     <= 1'b0;
         letter_valid_q <= 1'b0;
         letter_len_q   <= '0;
         letter_bits_q  <= '0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         key_meta_q     <= bus.key_in;
         key_s_q        <= key_meta_q;
         key_prev_q     <= key_s_q;
         press_cnt_q    <= press_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         sym_cnt_q      <= sym_cnt_d;
         sym_buf_q      <= sym_buf_d;
         sym_valid_q    <= sym_valid_d;
         sym_dash_q     <= sym_dash_d;
         letter_valid_q <= letter_valid_d;
         letter_len_q   <= letter_len_d;
         letter_bits_q  <= letter_bits_d;
         err_q          <= err_d;
      end
   end

   assign bus.sym_valid    = sym_valid_q;
   assign bus.sym_dash     = sym_dash_q;
   assign bus.letter_valid = letter_valid_q;
   assign bus.letter_len   = letter_len_q;
   assign bus.letter_bits  = letter_bits_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed, table-driven bench for morse_key_decoder (tick every 10 clk).
module tb_morse_key_decoder;
   logic clk;
   logic rst;
   int   ph;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   morse_key_decoder_if bus();

   morse_key_decoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tick generator: tick is high in cycles where ph == 0.
   initial begin
      ph = 0;
      cyc = 0;
      bus.tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc = cyc + 1;
         ph = (ph == 9) ? 0 : ph + 1;
         bus.tick = (ph == 0);
      end
   end

   // Event monitor, sampled on the falling edge.
   int          sym_n, letter_n, err_n;
   int          sym_cyc, letter_cyc;
   logic [63:0] dash_hist;
   logic [2:0]  last_len;
   logic [3:0]  last_bits;

   initial begin
      sym_n = 0; letter_n = 0; err_n = 0;
      sym_cyc = 0; letter_cyc = 0;
      dash_hist = '0; last_len = '0; last_bits = '0;
      forever begin
         @(negedge clk);
         if (bus.sym_valid) begin
            dash_hist[sym_n[5:0]] = bus.sym_dash;
            sym_n = sym_n + 1;
            sym_cyc = cyc;
         end
         if (bus.letter_valid) begin
            letter_n = letter_n + 1;
            last_len = bus.letter_len;
            last_bits = bus.letter_bits;
            letter_cyc = cyc;
         end
         if (bus.err) err_n = err_n + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct packed {
      logic [2:0]      n;
      logic [4:0][4:0] press;
      logic [4:0]      rel_early;
      logic [4:0][2:0] gap;
      logic [4:0]      rise_early;
      logic [2:0]      exp_syms;
      logic [4:0]      exp_dash;
      logic [1:0]      exp_letters;
      logic [2:0]      exp_len;
      logic [3:0]      exp_bits;
      logic [1:0]      exp_err;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_ph(input int p);
      do begin
         @(posedge clk);
         #2;
      end while (ph != p);
   endtask

   // Releases at ph 0 count whole tick periods; ph 8 makes the edge coincide with the next tick.
   task automatic run_vec(input vec_t v);
      wait_ph(0);
      bus.key_in = 1'b1;
      for (int i = 0; i < int'(v.n); i++) begin
         repeat (int'(v.press[i])) wait_ph(0);
         if (v.rel_early[i]) wait_ph(8);
         bus.key_in = 1'b0;
         if (i < int'(v.n) - 1) begin
            repeat (int'(v.gap[i])) wait_ph(0);
            if (v.rise_early[i]) wait_ph(8);
            bus.key_in = 1'b1;
         end
      end
      repeat (8) wait_ph(0);
   endtask

   task automatic check_vec(input int idx);
      int         b_sym, b_let, b_err, d_sym;
      logic [4:0] act_dash;
      vec_t       v;
      string      tag;
      v = vecs[idx];
      b_sym = sym_n; b_let = letter_n; b_err = err_n;
      run_vec(v);
      d_sym = sym_n - b_sym;
      act_dash = '0;
      for (int i = 0; i < 5; i++)
         if (i < d_sym) act_dash[i] = dash_hist[6'(b_sym + i)];
      tag = $sformatf("vec%0d", idx);
      chk({tag, " sym count"}, d_sym, int'(v.exp_syms));
      chk({tag, " sym dash"}, int'(act_dash), int'(v.exp_dash));
      chk({tag, " letter count"}, letter_n - b_let, int'(v.exp_letters));
      chk({tag, " err count"}, err_n - b_err, int'(v.exp_err));
      if (v.exp_letters != 2'd0) begin
         chk({tag, " letter_len"}, int'(last_len), int'(v.exp_len));
         chk({tag, " letter_bits"}, int'(last_bits), int'(v.exp_bits));
      end
   endtask

   int b_sym, b_let, b_err, rel;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      bus.key_in = 1'b0;

      //              n     press                                    rel_e    gap                                  rise_e   syms  dash      lets  len   bits     err
      vecs[0] = '{3'd1, {5'd0,5'd0,5'd0,5'd0,5'd1}, 5'b00000, {3'd0,3'd0,3'd0,3'd0,3'd0}, 5'b00000, 3'd1, 5'b00000, 2'd1, 3'd1, 4'b0000, 2'd0};
      vecs[1] = '{3'd4, {5'd0,5'd1,5'd1,5'd1,5'd4}, 5'b00000, {3'd0,3'd0,3'd2,3'd2,3'd2}, 5'b00000, 3'd4, 5'b00001, 2'd1, 3'd4, 4'b0001, 2'd0};
      vecs[2] = '{3'd2, {5'd0,5'd0,5'd0,5'd2,5'd2}, 5'b00010, {3'd0,3'd0,3'd0,3'd0,3'd2}, 5'b00000, 3'd2, 5'b00010, 2'd1, 3'd2, 4'b0010, 2'd0};
      vecs[3] = '{3'd2, {5'd0,5'd0,5'd0,5'd1,5'd1}, 5'b00000, {3'd0,3'd0,3'd0,3'd0,3'd4}, 5'b00001, 3'd2, 5'b00000, 2'd1, 3'd2, 4'b0000, 2'd0};
      vecs[4] = '{3'd5, {5'd1,5'd1,5'd1,5'd1,5'd1}, 5'b00000, {3'd1,3'd1,3'd1,3'd1,3'd1}, 5'b00000, 3'd4, 5'b00000, 2'd0, 3'd0, 4'b0000, 2'd1};
      vecs[5] = vecs[0];

      repeat (3) @(posedge clk);
      #2;
      chk("reset outputs", int'({bus.sym_valid, bus.sym_dash, bus.letter_valid,
                                 bus.letter_len, bus.letter_bits, bus.err}), 0);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) check_vec(i);

      // Latency of sym_valid after release and of letter_valid after the closing tick.
      wait_ph(0);
      bus.key_in = 1'b1;
      wait_ph(0);
      bus.key_in = 1'b0;
      rel = cyc;
      repeat (8) wait_ph(0);
      chk("sym_valid latency", sym_cyc - rel, 3);
      chk("letter_valid latency", letter_cyc - rel, 51);

      // Long press: err on the 15th tick, nothing on release.
      b_sym = sym_n; b_let = letter_n; b_err = err_n;
      wait_ph(0);
      bus.key_in = 1'b1;
      repeat (15) wait_ph(0);
      chk("long press err before tick15", err_n - b_err, 0);
      repeat (2) begin
         @(posedge clk);
         #2;
      end
      chk("long press err at tick15", err_n - b_err, 1);
      repeat (5) wait_ph(0);
      bus.key_in = 1'b0;
      repeat (8) wait_ph(0);
      chk("long press sym count", sym_n - b_sym, 0);
      chk("long press letter count", letter_n - b_let, 0);
      chk("long press err count", err_n - b_err, 1);
      check_vec(0);

      // Reset mid-letter discards the partial letter.
      b_sym = sym_n; b_let = letter_n;
      wait_ph(0);
      bus.key_in = 1'b1;
      wait_ph(0);
      bus.key_in = 1'b0;
      repeat (2) wait_ph(0);
      bus.key_in = 1'b1;
      wait_ph(0);
      bus.key_in = 1'b0;
      wait_ph(0);
      chk("pre-reset sym count", sym_n - b_sym, 2);
      rst = 1'b0;
      @(posedge clk);
      #2;
      chk("mid reset outputs", int'({bus.sym_valid, bus.sym_dash, bus.letter_valid,
                                     bus.letter_len, bus.letter_bits, bus.err}), 0);
      rst = 1'b1;
      repeat (8) wait_ph(0);
      chk("post-reset letter count", letter_n - b_let, 0);
      check_vec(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
